bcd_convert_arbiter: RTL

Shared, iterative binary-to-BCD conversion engine with a round-robin arbiter in front of it. Several game-side requesters (score, high score, timer) each submit a binary value. The block grants one requester at a time and runs shift-and-add-3 one bit per clock. It returns packed BCD digits to the 7-segment display path, tagged with the requester index.

---
 rtl/bcd_convert_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbitrated, shared shift-and-add-3 binary-to-BCD converter (one bit per clock).
// Define BCD_SATURATE_EN to saturate out-of-range results to all 9s and flag OVERFLOW.
module bcd_convert_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned BIN_WIDTH = 14,
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned IDW       = 2
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic [NUM_REQ-1:0]           REQ,
    input  logic [NUM_REQ*BIN_WIDTH-1:0] BIN_IN,
    output logic [NUM_REQ-1:0]           GNT,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [IDW-1:0]               DONE_ID,
    output logic [4*DIGITS-1:0]          BCD_OUT,
    output logic                         OVERFLOW
);

    localparam int unsigned CW = $clog2(BIN_WIDTH + 1);
    localparam int unsigned DW = 4 * DIGITS;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [BIN_WIDTH-1:0] sr_q, sr_d;
    logic [DW-1:0]        dig_q, dig_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [IDW-1:0]       done_id_q, done_id_d;
    logic [DW-1:0]        bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;

    logic                 found;
    logic [IDW-1:0]       sel;
    logic [DW-1:0]        adj;
    logic [DW-1:0]        shifted;
    logic                 carry;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        sr_d      = sr_q;
        dig_d     = dig_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        gnt_d     = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;

        // Search starts just after the last winner and wraps, giving round-robin fairness.
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            if (!found && REQ[(int'(last_q) + k) % int'(NUM_REQ)]) begin
                found = 1'b1;
                sel   = IDW'((int'(last_q) + k) % int'(NUM_REQ));
            end
        end

        adj = dig_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[DW-2:0], sr_q[BIN_WIDTH-1]};
        carry   = adj[DW-1];

        case (state_q)
            StIdle: begin
                if (found) begin
                    sr_d     = BIN_IN[int'(sel)*BIN_WIDTH +: BIN_WIDTH];
                    dig_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CW'(BIN_WIDTH);
                    last_d   = sel;
                    gnt_d    = NUM_REQ'(1) << sel;
                    busy_d   = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                dig_d    = shifted;
                sr_d     = {sr_q[BIN_WIDTH-2:0], 1'b0};
                sticky_d = sticky_q | carry;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_id_d = last_q;
                    state_d   = StIdle;
`ifdef BCD_SATURATE_EN
                    if (sticky_q | carry) begin
                        bcd_d = {DIGITS{4'h9}};
                        ovf_d = 1'b1;
                    end else begin
                        bcd_d = shifted;
                        ovf_d = 1'b0;
                    end
`else
                    bcd_d = shifted;
                    ovf_d = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= StIdle;
            last_q    <= IDW'(NUM_REQ - 1);
            sr_q      <= '0;
            dig_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            sr_q      <= sr_d;
            dig_q     <= dig_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign GNT      = gnt_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign DONE_ID  = done_id_q;
    assign BCD_OUT  = bcd_q;
    assign OVERFLOW = ovf_q;

endmodule
